// File: rtl/systolic_mem_seq.sv
// systolic_mem_seq: sequences BRAM read/write addresses and operand steering
// for the systolic array in AS (stream, drain, save) and SA (preload weights,
// stream, delayed write-back) modes. Addresses are decoded from the registered
// state/beat/line counters, so they hold naturally while the sequencer is stalled.
module systolic_mem_seq #(
  parameter int DW       = 64,
  parameter int AW       = 32,
  parameter int LANES    = 4,
  parameter int PIPE_LAT = 4,
  parameter int SIZE_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              en,
  input  logic [SIZE_W-1:0] cfg_size,
  input  logic [AW-1:0]     cfg_base_left,
  input  logic [AW-1:0]     cfg_base_right,
  input  logic [AW-1:0]     cfg_base_add,
  input  logic [AW-1:0]     cfg_base_save,
  input  logic [AW-1:0]     cfg_step,
  input  logic [AW-1:0]     cfg_stride_left,
  input  logic [AW-1:0]     cfg_stride_right,
  output logic [AW-1:0]     rd_addr_left,
  output logic [AW-1:0]     rd_addr_right,
  output logic [AW-1:0]     rd_addr_add,
  output logic [AW-1:0]     wr_addr_save,
  output logic              wr_en_save,
  input  logic [DW-1:0]     rd_data_left,
  input  logic [DW-1:0]     rd_data_right,
  input  logic [DW-1:0]     rd_data_add,
  output logic [DW-1:0]     data_left,
  output logic [DW-1:0]     data_right,
  output logic [DW-1:0]     data_adder,
  output logic              busy,
  output logic              done,
  output logic              sys_mode,
  output logic              sys_calc,
  output logic              tsel,
  output logic              tsel_rst
);

  localparam int B_W = $clog2(LANES);
  // Line counter must reach N+PIPE_LAT-1 for the largest N.
  localparam int L_W = $clog2((2 ** SIZE_W) + PIPE_LAT);
  localparam logic [B_W-1:0] B_LAST = B_W'(LANES - 1);
  localparam logic [B_W-1:0] B_ONE  = B_W'(1);
  localparam logic [L_W-1:0] L_ONE  = L_W'(1);
  localparam logic [L_W-1:0] L_PIPE = L_W'(PIPE_LAT);

  typedef enum logic [2:0] {
    IDLE, AS_CALC, AS_DRAIN, AS_SAVE, SA_LOAD, SA_CALC, FINISH
  } state_e;

  typedef struct packed {
    logic              mode;
    logic [SIZE_W-1:0] size;
    logic [AW-1:0]     base_left;
    logic [AW-1:0]     base_right;
    logic [AW-1:0]     base_add;
    logic [AW-1:0]     base_save;
    logic [AW-1:0]     step;
    logic [AW-1:0]     stride_left;
    logic [AW-1:0]     stride_right;
  } cfg_t;

  state_e         state_q, state_d;
  logic [B_W-1:0] b_q, b_d;
  logic [L_W-1:0] l_q, l_d;
  cfg_t           cfg_q, cfg_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tsel_q, tsel_d;
  logic           tsel_rst_q, tsel_rst_d;

  logic [L_W-1:0] size_l;
  logic [L_W-1:0] k_line;

  assign size_l = L_W'(cfg_q.size);
  // Write-back line index in SA_CALC; only meaningful once l >= PIPE_LAT.
  assign k_line = l_q - L_PIPE;

  // base + line*step + beat*stride, all modulo 2^AW.
  function automatic logic [AW-1:0] addr_calc(input logic [AW-1:0]  base,
                                              input logic [L_W-1:0] line,
                                              input logic [AW-1:0]  step,
                                              input logic [B_W-1:0] beat,
                                              input logic [AW-1:0]  stride);
    return base + AW'(line) * step + AW'(beat) * stride;
  endfunction

  // Next-state logic: command acceptance, beat/line counters, mode FSM, tsel.
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    l_d        = l_q;
    cfg_d      = cfg_q;
    tsel_d     = tsel_q;
    tsel_rst_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d.mode         = mode;
          cfg_d.size         = cfg_size;
          cfg_d.base_left    = cfg_base_left;
          cfg_d.base_right   = cfg_base_right;
          cfg_d.base_add     = cfg_base_add;
          cfg_d.base_save    = cfg_base_save;
          cfg_d.step         = cfg_step;
          cfg_d.stride_left  = cfg_stride_left;
          cfg_d.stride_right = cfg_stride_right;
          b_d        = '0;
          l_d        = '0;
          tsel_d     = 1'b1;
          tsel_rst_d = 1'b1;
          if (cfg_size == '0) state_d = FINISH;
          else                state_d = mode ? SA_LOAD : AS_CALC;
        end
      end
      FINISH: begin
        state_d = IDLE;
        b_d     = '0;
        l_d     = '0;
      end
      default: begin
        if (en) begin
          b_d = b_q + B_ONE;
          if (b_q == B_LAST) begin
            tsel_d = ~tsel_q;
            l_d    = l_q + L_ONE;
            case (state_q)
              AS_CALC:  if (l_q == size_l - L_ONE) begin state_d = AS_DRAIN; l_d = '0; end
              AS_DRAIN: if (l_q == L_PIPE - L_ONE) begin state_d = AS_SAVE;  l_d = '0; end
              AS_SAVE:  begin state_d = FINISH;  l_d = '0; end
              SA_LOAD:  begin state_d = SA_CALC; l_d = '0; end
              SA_CALC:  if (l_q == size_l + L_PIPE - L_ONE) begin state_d = FINISH; l_d = '0; end
              default:  ;
            endcase
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State, counters, latched config and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      b_q        <= '0;
      l_q        <= '0;
      cfg_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tsel_q     <= 1'b1;
      tsel_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      l_q        <= l_d;
      cfg_q      <= cfg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tsel_q     <= tsel_d;
      tsel_rst_q <= tsel_rst_d;
    end
  end

  // Address generation and operand steering decoded from the current state.
  always_comb begin
    rd_addr_left  = '0;
    rd_addr_right = '0;
    rd_addr_add   = '0;
    wr_addr_save  = '0;
    wr_en_save    = 1'b0;
    data_left     = '0;
    data_right    = '0;
    sys_calc      = 1'b0;
    case (state_q)
      AS_CALC: begin
        rd_addr_left  = addr_calc(cfg_q.base_left,  l_q, cfg_q.step, b_q, cfg_q.stride_left);
        rd_addr_right = addr_calc(cfg_q.base_right, l_q, cfg_q.step, b_q, cfg_q.stride_right);
        data_left     = rd_data_left;
        data_right    = rd_data_right;
        sys_calc      = 1'b1;
      end
      AS_DRAIN: sys_calc = 1'b1;
      AS_SAVE: begin
        rd_addr_add  = addr_calc(cfg_q.base_add,  '0, cfg_q.step, b_q, cfg_q.stride_right);
        wr_addr_save = addr_calc(cfg_q.base_save, '0, cfg_q.step, b_q, cfg_q.stride_right);
        wr_en_save   = en;
      end
      SA_LOAD: begin
        // Weights are loaded last lane first.
        rd_addr_right = addr_calc(cfg_q.base_right, '0, cfg_q.step, B_LAST - b_q, cfg_q.stride_right);
        data_right    = rd_data_right;
      end
      SA_CALC: begin
        sys_calc = 1'b1;
        if (l_q < size_l) begin
          rd_addr_left = addr_calc(cfg_q.base_left, l_q, cfg_q.step, b_q, cfg_q.stride_left);
          data_left    = rd_data_left;
        end
        if (l_q >= L_PIPE) begin
          rd_addr_add  = addr_calc(cfg_q.base_add,  k_line, cfg_q.step, b_q, cfg_q.stride_left);
          wr_addr_save = addr_calc(cfg_q.base_save, k_line, cfg_q.step, b_q, cfg_q.stride_left);
          wr_en_save   = en;
        end
      end
      default: ;
    endcase
  end

  assign data_adder = rd_data_add;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sys_mode   = cfg_q.mode;
  assign tsel       = tsel_q;
  assign tsel_rst   = tsel_rst_q;

endmodule

// File: tb/tb_systolic_mem_seq.sv
// Directed testbench for systolic_mem_seq with hand-computed expectations.
module tb_systolic_mem_seq;

  localparam logic [63:0] DL = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DR = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DA = 64'h9999_AAAA_BBBB_CCCC;

  logic        clk = 1'b0;
  logic        rst, start, mode, en;
  logic [10:0] cfg_size;
  logic [31:0] cfg_base_left, cfg_base_right, cfg_base_add, cfg_base_save;
  logic [31:0] cfg_step, cfg_stride_left, cfg_stride_right;
  logic [31:0] rd_addr_left, rd_addr_right, rd_addr_add, wr_addr_save;
  logic        wr_en_save;
  logic [63:0] rd_data_left, rd_data_right, rd_data_add;
  logic [63:0] data_left, data_right, data_adder;
  logic        busy, done, sys_mode, sys_calc, tsel, tsel_rst;

  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt, done_at, first_wr;
  logic [31:0] last_wr;

  logic [63:0] as_left [8] = '{64'h100, 64'h140, 64'h180, 64'h1C0,
                               64'h108, 64'h148, 64'h188, 64'h1C8};
  logic [63:0] sa_load [4] = '{64'h260, 64'h240, 64'h220, 64'h200};

  always #5 clk = ~clk;

  systolic_mem_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .en(en),
    .cfg_size(cfg_size),
    .cfg_base_left(cfg_base_left), .cfg_base_right(cfg_base_right),
    .cfg_base_add(cfg_base_add), .cfg_base_save(cfg_base_save),
    .cfg_step(cfg_step), .cfg_stride_left(cfg_stride_left),
    .cfg_stride_right(cfg_stride_right),
    .rd_addr_left(rd_addr_left), .rd_addr_right(rd_addr_right),
    .rd_addr_add(rd_addr_add), .wr_addr_save(wr_addr_save),
    .wr_en_save(wr_en_save),
    .rd_data_left(rd_data_left), .rd_data_right(rd_data_right),
    .rd_data_add(rd_data_add),
    .data_left(data_left), .data_right(data_right), .data_adder(data_adder),
    .busy(busy), .done(done), .sys_mode(sys_mode), .sys_calc(sys_calc),
    .tsel(tsel), .tsel_rst(tsel_rst)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns at the drive point of the first busy cycle.
  task automatic issue(input logic m, input logic [10:0] n);
    tick;
    start    = 1'b1;
    mode     = m;
    cfg_size = n;
    tick;
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     64'(busy),          64'd0);
    check({tag, "_done"},     64'(done),          64'd0);
    check({tag, "_sys_mode"}, 64'(sys_mode),      64'd0);
    check({tag, "_sys_calc"}, 64'(sys_calc),      64'd0);
    check({tag, "_tsel"},     64'(tsel),          64'd1);
    check({tag, "_tsel_rst"}, 64'(tsel_rst),      64'd0);
    check({tag, "_wr_en"},    64'(wr_en_save),    64'd0);
    check({tag, "_rd_left"},  64'(rd_addr_left),  64'd0);
    check({tag, "_rd_right"}, 64'(rd_addr_right), 64'd0);
    check({tag, "_wr_addr"},  64'(wr_addr_save),  64'd0);
    check({tag, "_dleft"},    data_left,          64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; en = 1'b1; cfg_size = '0;
    cfg_base_left = 32'h100; cfg_base_right = 32'h1000;
    cfg_base_add = 32'h2000; cfg_base_save = 32'h3000;
    cfg_step = 32'd8; cfg_stride_left = 32'h40; cfg_stride_right = 32'h10;
    rd_data_left = DL; rd_data_right = DR; rd_data_add = DA;

    // Reset state
    repeat (3) tick;
    @(negedge clk);
    check_idle_outputs("rst");
    tick;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");
    check("data_adder", data_adder, DA);

    // AS, N=2
    issue(1'b0, 11'd2);
    wr_cnt = 0; done_at = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (wr_en_save) wr_cnt++;
      if (done && done_at == 0) done_at = c;
      if (c <= 8) check("as_rd_left", 64'(rd_addr_left), as_left[c-1]);
      case (c)
        1: begin
          check("as_tsel_rst_pulse", 64'(tsel_rst), 64'd1);
          check("as_busy", 64'(busy), 64'd1);
          check("as_data_left", data_left, DL);
          check("as_sys_mode", 64'(sys_mode), 64'd0);
        end
        2: check("as_tsel_rst_end", 64'(tsel_rst), 64'd0);
        4: check("as_tsel_b3", 64'(tsel), 64'd1);
        5: check("as_tsel_toggle", 64'(tsel), 64'd0);
        6: begin
          check("as_rd_right", 64'(rd_addr_right), 64'h1018);
          check("as_data_right", data_right, DR);
        end
        12: begin
          check("as_drain_calc", 64'(sys_calc), 64'd1);
          check("as_drain_addr", 64'(rd_addr_left), 64'd0);
          check("as_drain_dleft", data_left, 64'd0);
        end
        25: begin
          check("as_save_wr0", 64'(wr_addr_save), 64'h3000);
          check("as_save_add0", 64'(rd_addr_add), 64'h2000);
          check("as_save_calc", 64'(sys_calc), 64'd0);
        end
        28: check("as_save_wr3", 64'(wr_addr_save), 64'h3030);
        30: begin
          check("as_busy_after", 64'(busy), 64'd0);
          check("as_done_after", 64'(done), 64'd0);
        end
        default: ;
      endcase
      tick;
    end
    check("as_writes", 64'(wr_cnt), 64'd4);
    check("as_done_at", 64'(done_at), 64'd29);

    // N=0 command
    issue(1'b0, 11'd0);
    wr_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (wr_en_save) wr_cnt++;
      if (c == 1) begin
        check("n0_busy1", 64'(busy), 64'd1);
        check("n0_done1", 64'(done), 64'd1);
      end
      if (c == 2) begin
        check("n0_busy2", 64'(busy), 64'd0);
        check("n0_done2", 64'(done), 64'd0);
      end
      tick;
    end
    check("n0_writes", 64'(wr_cnt), 64'd0);

    // SA, N=3
    cfg_base_right = 32'h200; cfg_stride_right = 32'h20;
    issue(1'b1, 11'd3);
    wr_cnt = 0; done_at = 0; first_wr = 0; last_wr = '0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (wr_en_save) begin
        wr_cnt++;
        if (first_wr == 0) first_wr = c;
        last_wr = wr_addr_save;
      end
      if (done && done_at == 0) done_at = c;
      if (c <= 4) check("sa_load_addr", 64'(rd_addr_right), sa_load[c-1]);
      case (c)
        2: begin
          check("sa_sys_mode", 64'(sys_mode), 64'd1);
          check("sa_load_calc", 64'(sys_calc), 64'd0);
          check("sa_load_dright", data_right, DR);
          check("sa_load_dleft", data_left, 64'd0);
        end
        5: begin
          check("sa_calc_on", 64'(sys_calc), 64'd1);
          check("sa_left0", 64'(rd_addr_left), 64'h100);
          check("sa_dleft0", data_left, DL);
        end
        16: check("sa_left_l2b3", 64'(rd_addr_left), 64'h1D0);
        17: check("sa_dleft_flush", data_left, 64'd0);
        21: check("sa_wr_k0", 64'(wr_addr_save), 64'h3000);
        32: check("sa_add_k2b3", 64'(rd_addr_add), 64'h20D0);
        default: ;
      endcase
      tick;
    end
    check("sa_writes", 64'(wr_cnt), 64'd12);
    check("sa_first_wr", 64'(first_wr), 64'd21);
    check("sa_last_wr", 64'(last_wr), 64'h30D0);
    check("sa_done_at", 64'(done_at), 64'd33);

    // Stall: 5 cycles in AS_CALC at b=3, 2 cycles in AS_SAVE
    cfg_base_right = 32'h1000; cfg_stride_right = 32'h10;
    issue(1'b0, 11'd2);
    wr_cnt = 0; done_at = 0;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (wr_en_save) wr_cnt++;
      if (done && done_at == 0) done_at = c;
      case (c)
        4: begin
          check("st_addr_c4", 64'(rd_addr_left), 64'h1C0);
          check("st_tsel_c4", 64'(tsel), 64'd1);
        end
        6: begin
          check("st_addr_hold", 64'(rd_addr_left), 64'h1C0);
          check("st_tsel_hold6", 64'(tsel), 64'd1);
        end
        8: check("st_tsel_hold8", 64'(tsel), 64'd1);
        9: check("st_addr_resume", 64'(rd_addr_left), 64'h1C0);
        10: begin
          check("st_addr_next", 64'(rd_addr_left), 64'h108);
          check("st_tsel_toggle", 64'(tsel), 64'd0);
        end
        31: check("st_wr_en_gated", 64'(wr_en_save), 64'd0);
        32: check("st_wr_addr_hold", 64'(wr_addr_save), 64'h3010);
        33: check("st_wr_resume", 64'(wr_en_save), 64'd1);
        35: check("st_wr_last", 64'(wr_addr_save), 64'h3030);
        default: ;
      endcase
      tick;
      en = !(((c + 1) >= 4 && (c + 1) <= 8) || (c + 1) == 31 || (c + 1) == 32);
    end
    check("st_writes", 64'(wr_cnt), 64'd4);
    check("st_done_at", 64'(done_at), 64'd36);

    // Start while busy is ignored; reset mid-SA_CALC
    en = 1'b1;
    cfg_base_right = 32'h200; cfg_stride_right = 32'h20;
    issue(1'b1, 11'd3);
    done_at = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done && done_at == 0) done_at = c;
      case (c)
        3: begin
          check("rb_load_addr", 64'(rd_addr_right), 64'h220);
          check("rb_sys_mode", 64'(sys_mode), 64'd1);
          check("rb_busy", 64'(busy), 64'd1);
        end
        4: check("rb_load_last", 64'(rd_addr_right), 64'h200);
        8: begin
          check("rb_calc_addr", 64'(rd_addr_left), 64'h1C0);
          check("rb_calc_on", 64'(sys_calc), 64'd1);
        end
        11: check_idle_outputs("rb_rst");
        default: ;
      endcase
      tick;
      start = (c == 1);
      if (c == 1) begin
        mode = 1'b0; cfg_size = 11'd1; cfg_base_right = 32'hFFF0;
      end
      rst = (c == 9);
    end
    check("rb_no_done", 64'(done_at), 64'd0);

    // Address wrap-around on the save port
    cfg_base_save = 32'hFFFF_FFF0; cfg_step = 32'd8; cfg_stride_left = 32'h40;
    cfg_base_right = 32'h200;
    issue(1'b1, 11'd3);
    done_at = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (done && done_at == 0) done_at = c;
      case (c)
        21: begin
          check("wrap_k0", 64'(wr_addr_save), 64'hFFFF_FFF0);
          check("wrap_en", 64'(wr_en_save), 64'd1);
        end
        25: check("wrap_k1", 64'(wr_addr_save), 64'hFFFF_FFF8);
        29: check("wrap_k2", 64'(wr_addr_save), 64'h0);
        32: check("wrap_k2b3", 64'(wr_addr_save), 64'hC0);
        default: ;
      endcase
      tick;
    end
    check("wrap_done_at", 64'(done_at), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/systolic_mem_seq.md
Name: systolic_mem_seq

Overview:
- Parametrised successor to the fixed 4-beat systolic memory controller.
- Sequences BRAM read/write addresses and data steering for the systolic array in two modes:
  - AS: stream both operands, drain, save.
  - SA: preload weights, stream the left operand, write back delayed results.
- Lane count, pipeline drain depth, and data/address widths are parameters; strides are runtime config.
- Adds a start/busy/done handshake and a stall input. Sits between the top-level command decoder and the three BRAM ports.

Parameters:
- DW, 64, BRAM data width.
- AW, 32, address width.
- LANES, 4, beats per line (≥2, power of 2); sets the width of beat counter b.
- PIPE_LAT, 4, array latency in lines (≥1).
- SIZE_W, 11, width of the matrix-size field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse; accepted only in IDLE
- mode  in  1  0=AS, 1=SA
- en  in  1  advance enable; 0 stalls the sequencer
- cfg_size  in  SIZE_W  matrix lines N
- cfg_base_left / cfg_base_right / cfg_base_add / cfg_base_save  in  AW  base addresses
- cfg_step  in  AW  byte step per line
- cfg_stride_left / cfg_stride_right  in  AW  byte step per beat (lane)
- rd_addr_left / rd_addr_right / rd_addr_add  out  AW  read addresses
- wr_addr_save  out  AW  write address
- wr_en_save  out  1  write strobe
- rd_data_left / rd_data_right / rd_data_add  in  DW  BRAM read data
- data_left / data_right / data_adder  out  DW  array operands
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE
- sys_mode  out  1  latched mode
- sys_calc  out  1  array compute enable
- tsel  out  1  transpose buffer select
- tsel_rst  out  1  transpose buffer sync reset

Behaviour:
- Reset: state IDLE, b=0, line l=0, config registers 0. Outputs: busy=0, done=0, sys_mode=0, sys_calc=0, tsel=1, tsel_rst=0, wr_en_save=0, all addresses 0.
- Start acceptance: start in IDLE latches all cfg_* and mode, clears b and l, sets tsel=1, pulses tsel_rst the following cycle. start while busy is ignored.
- Counters: b counts 0..LANES-1. l increments when b wraps. Both counters advance only when en=1.
- Stall: en=0 freezes state, b, l, and tsel. wr_en_save is forced to 0. Addresses hold their values.
- State machine: IDLE, AS_CALC, AS_DRAIN, AS_SAVE, SA_LOAD, SA_CALC, FINISH. FINISH lasts one cycle, pulses done, then goes to IDLE.
- Empty command: if N=0, start goes directly to FINISH. No reads and no writes occur.
- AS_CALC, l=0..N-1:
  - rd_addr_left = base_left + l*step + b*stride_left
  - rd_addr_right = base_right + l*step + b*stride_right
  - data_left = rd_data_left; data_right = rd_data_right; sys_calc=1
  - Exit to AS_DRAIN after the last beat of line N-1; l is cleared.
- AS_DRAIN: PIPE_LAT lines, no reads, sys_calc=1. Exit to AS_SAVE; l is cleared.
- AS_SAVE: one line of LANES beats.
  - rd_addr_add = base_add + b*stride_right
  - wr_addr_save = base_save + b*stride_right
  - wr_en_save=1 on every enabled beat; sys_calc=0
  - Exit to FINISH.
- SA_LOAD: LANES beats.
  - rd_addr_right = base_right + (LANES-1-b)*stride_right
  - data_right = rd_data_right; sys_calc=0
  - Exit to SA_CALC with b=0, l=0.
- SA_CALC, l=0..N+PIPE_LAT-1, sys_calc=1:
  - For l<N: rd_addr_left = base_left + l*step + b*stride_left; data_left = rd_data_left.
  - For l≥N: data_left=0.
  - For l≥PIPE_LAT: with k=l-PIPE_LAT, rd_addr_add = base_add + k*step + b*stride_left, wr_addr_save = base_save + k*step + b*stride_left, wr_en_save=1.
  - Exit to FINISH after line N+PIPE_LAT-1.
- Data steering: data_adder = rd_data_add at all times. data_left and data_right are 0 outside the states listed above. Steering is combinational.
- tsel: toggles on every enabled cycle where b=LANES-1.
- Arithmetic: all address arithmetic is modulo 2^AW; products are truncated to AW bits.
- Reset mid-operation: rst has priority over start and en; the block returns to IDLE within one cycle with no done pulse.

Test Plan:
- AS: LANES=4, N=2, base_left=0x100, step=8, stride_left=0x40. Expected rd_addr_left sequence 0x100, 0x140, 0x180, 0x1C0, 0x108, ...; 16 drain cycles; 4 writes to base_save + {0,1,2,3}*stride_right; done pulse 8+16+4+1 cycles after start.
- SA: N=3, PIPE_LAT=4, base_right=0x200, stride_right=0x20. Expected load addresses 0x260, 0x240, 0x220, 0x200. First wr_en_save at line 4 beat 0 with k=0; exactly 12 writes; last write k=2, b=3.
- Stall: en=0 for 5 cycles in the middle of AS_CALC. Addresses, b, l, and tsel hold; wr_en_save=0; total cycle count extends by exactly 5.
- N=0 start: busy=1 for one cycle, done pulses next, and no wr_en_save occurs.
- start asserted while busy is ignored and the config is unchanged. A rst pulse mid-SA_CALC produces IDLE next cycle, all outputs at reset values, and no done pulse.
- Wrap-around: base_save=0xFFFFFFF0, step=8. Expected write addresses 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000.
